// File: rtl/start_job_engine_if.sv
// Avalon-MM read-master bus between the job engine and on-chip memory.
// A request is accepted when avm_read & ~avm_waitrequest; the master holds avm_read/avm_address until then; readdatavalid cannot be stalled.
interface start_job_engine_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/start_job_engine.sv
// Runs one read-and-accumulate job over job_len words per software start level,
// with pipelined Avalon reads and a 4-phase start/done handshake.
module start_job_engine #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 11,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    job_len,
  start_job_engine_if.master  avm,
  output logic                busy,
  output logic                done,
  output logic [31:0]         result,
  output logic                result_ovf,
  output logic [1:0]          dbg_state_o
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     rcv_q, rcv_d;
  logic [3:0]        out_q, out_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              rdv_en;
  logic [32:0]       sum;
  logic [ADDR_W-1:0] offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rcv_q    <= '0;
      out_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rcv_q    <= rcv_d;
      out_q    <= out_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Request decision uses registered idx/outstanding only, so readdatavalid never reaches avm_read.
  always_comb begin
    avm.avm_read    = (state_q == S_ISSUE) && (idx_q < len_q) && (out_q < 4'(MAX_OUT));
    offset          = ADDR_W'(idx_q) << 2;
    avm.avm_address = avm.avm_read ? (base_q + offset) : '0;
    busy            = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done            = (state_q == S_DONE);
    result          = result_q;
    result_ovf      = ovf_q;
    dbg_state_o     = state_q;
  end

  assign accept = avm.avm_read & ~avm.avm_waitrequest;
  assign rdv_en = avm.avm_readdatavalid & ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign sum    = {1'b0, result_q} + {1'b0, avm.avm_readdata};

  always_comb begin
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rcv_d    = rcv_q;
    out_d    = out_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = CW'(job_len);
          idx_d    = '0;
          rcv_d    = '0;
          out_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (accept) idx_d = idx_q + CW'(1);
        if (rdv_en) begin
          result_d = sum[31:0];
          ovf_d    = ovf_q | sum[32];
          rcv_d    = rcv_q + CW'(1);
        end
        out_d = out_q + {3'b000, accept} - {3'b000, rdv_en};
      end
      default: ;
    endcase
  end

  // DRAIN looks at rcv_d so done rises the cycle right after the final readdatavalid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (job_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (accept && (idx_q == len_q - CW'(1))) state_d = S_DRAIN;
      S_DRAIN: if (rcv_d == len_q) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_start_job_engine.sv
// Directed bench for start_job_engine: a table of jobs against an Avalon memory
// model with configurable latency/waitrequest, plus a reset-mid-drain sequence.
module tb_start_job_engine;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 11;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [LEN_W-1:0]  job_len = '0;
  logic              busy, done, result_ovf;
  logic [31:0]       result;
  logic [1:0]        dbg_state;

  start_job_engine_if #(.ADDR_W(ADDR_W)) avm_bus ();

  start_job_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .job_len     (job_len),
    .avm         (avm_bus),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_ovf  (result_ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory slave model, driven mid-cycle on the falling edge
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic [31:0] mem [0:4095];
  rsp_t        rsp_q[$];
  logic [31:0] acc_addr [0:8191];
  int          acc_cyc  [0:8191];
  int          total_acc = 0, total_rdv = 0, last_rdv_cyc = 0;
  int          stall_err = 0, outst_err = 0;
  int          lat_min = 1, lat_max = 1;
  bit          wait_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        wr;
  rsp_t        r;

  always @(negedge clk) begin
    if (prev_stall && (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== prev_addr)) stall_err++;
    if (total_acc - total_rdv > MAX_OUT) outst_err++;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      avm_bus.avm_readdatavalid = 1'b1;
      avm_bus.avm_readdata      = rsp_q[0].data;
      void'(rsp_q.pop_front());
      total_rdv++;
      last_rdv_cyc = cyc;
    end
    wr = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
    avm_bus.avm_waitrequest = wr;
    if (avm_bus.avm_read === 1'b1 && !wr) begin
      r.data = mem[avm_bus.avm_address[13:2]];
      r.due  = cyc + int'($urandom_range(lat_min, lat_max));
      rsp_q.push_back(r);
      if (total_acc < 8192) begin
        acc_addr[total_acc] = avm_bus.avm_address;
        acc_cyc[total_acc]  = cyc;
      end
      total_acc++;
    end
    prev_stall = (avm_bus.avm_read === 1'b1) && wr;
    prev_addr  = avm_bus.avm_address;
  end

  // scoreboard counters
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [31:0] base;
    int          lmin;
    int          lmax;
    bit          wt;
    int          pat;
    logic [31:0] exp_res;
    bit          exp_ovf;
    bit          consec;
    int          hold;
    bit          drop;
  } vec_t;

  function automatic logic [31:0] word_of(input int pat, input int i);
    case (pat)
      0:       return 32'(i + 1);
      1:       return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_0002;
      2:       return 32'hDEAD_BEEF;
      3:       return 32'd5;
      default: return 32'd0;
    endcase
  endfunction

  // driver: one full 4-phase job with all per-job checks
  task automatic run_job(input vec_t v);
    int acc0, st0, oe0, n, errs;
    acc0 = total_acc;
    st0  = stall_err;
    oe0  = outst_err;
    lat_min = v.lmin;
    lat_max = v.lmax;
    wait_en = v.wt;
    for (int i = 0; i < v.len; i++) mem[12'((v.base >> 2) + 32'(i))] = word_of(v.pat, i);
    @(negedge clk);
    base_addr = v.base;
    job_len   = LEN_W'(v.len);
    start     = 1'b1;
    @(negedge clk);
    n = 1;
    if (v.len > 0) begin
      check({v.name, "/start_read"}, 32'(avm_bus.avm_read), 32'd1);
      check({v.name, "/start_addr"}, avm_bus.avm_address, v.base);
    end
    while (done !== 1'b1 && n < 20000) begin
      if (v.drop && n == 3) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check({v.name, "/done_seen"}, 32'(done), 32'd1);
    if (v.len == 0) check({v.name, "/done_cycle"}, 32'(n), 32'd1);
    else            check({v.name, "/done_latency"}, 32'(cyc - last_rdv_cyc), 32'd1);
    check({v.name, "/busy_low"}, 32'(busy), 32'd0);
    check({v.name, "/result"}, result, v.exp_res);
    check({v.name, "/ovf"}, 32'(result_ovf), 32'(v.exp_ovf));
    check({v.name, "/reads"}, 32'(total_acc - acc0), 32'(v.len));
    errs = 0;
    for (int k = 0; k < v.len; k++)
      if (acc_addr[acc0 + k] !== v.base + 32'(4 * k)) errs++;
    check({v.name, "/addr_seq"}, 32'(errs), 32'd0);
    check({v.name, "/stall_stable"}, 32'(stall_err - st0), 32'd0);
    check({v.name, "/outstanding"}, 32'(outst_err - oe0), 32'd0);
    if (v.consec) check({v.name, "/back_to_back"}, 32'(acc_cyc[acc0 + v.len - 1] - acc_cyc[acc0]), 32'(v.len - 1));
    if (v.hold > 0) begin
      errs = 0;
      repeat (v.hold) begin
        @(negedge clk);
        if (done !== 1'b1 || busy !== 1'b0) errs++;
      end
      check({v.name, "/hold_done"}, 32'(errs), 32'd0);
      check({v.name, "/hold_no_rerun"}, 32'(total_acc - acc0), 32'(v.len));
    end
    start = 1'b0;
    @(negedge clk);
    check({v.name, "/done_fall"}, 32'(done), 32'd0);
    check({v.name, "/result_held"}, result, v.exp_res);
  endtask

  vec_t vecs [8];
  vec_t v2;
  int   n, rdv0;

  initial begin
    vecs[0] = '{"basic",    8,    32'h100, 2, 2, 1'b0, 0, 32'd36,        1'b0, 1'b1, 0, 1'b0};
    vecs[1] = '{"backpr",   8,    32'h100, 1, 8, 1'b1, 0, 32'd36,        1'b0, 1'b0, 0, 1'b0};
    vecs[2] = '{"overflow", 2,    32'h040, 3, 3, 1'b0, 1, 32'h1,         1'b1, 1'b0, 0, 1'b0};
    vecs[3] = '{"len0",     0,    32'h300, 1, 1, 1'b0, 0, 32'd0,         1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{"len1",     1,    32'h080, 1, 1, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0};
    vecs[5] = '{"len2047",  2047, 32'h000, 2, 2, 1'b0, 0, 32'h001F_FC00, 1'b0, 1'b1, 0, 1'b0};
    vecs[6] = '{"hold",     4,    32'h100, 2, 2, 1'b0, 0, 32'd10,        1'b0, 1'b0, 6, 1'b0};
    vecs[7] = '{"drop",     5,    32'h100, 4, 4, 1'b0, 0, 32'd15,        1'b0, 1'b0, 0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst/read",   32'(avm_bus.avm_read), 32'd0);
    check("rst/addr",   avm_bus.avm_address, 32'd0);
    check("rst/busy",   32'(busy), 32'd0);
    check("rst/done",   32'(done), 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/ovf",    32'(result_ovf), 32'd0);
    check("rst/state",  32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // reset while three reads are in flight in DRAIN
    lat_min = 10;
    lat_max = 10;
    wait_en = 1'b0;
    for (int i = 0; i < 3; i++) mem[12'(32'h100 + 32'(i))] = 32'd7;
    @(negedge clk);
    base_addr = 32'h400;
    job_len   = LEN_W'(3);
    start     = 1'b1;
    n = 0;
    while (dbg_state !== 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid/reached_drain", 32'(dbg_state), 32'd2);
    check("rstmid/in_flight", 32'(total_acc - total_rdv), 32'd3);
    rdv0  = total_rdv;
    reset = 1'b1;
    #1;
    check("rstmid/read",   32'(avm_bus.avm_read), 32'd0);
    check("rstmid/addr",   avm_bus.avm_address, 32'd0);
    check("rstmid/busy",   32'(busy), 32'd0);
    check("rstmid/done",   32'(done), 32'd0);
    check("rstmid/result", result, 32'd0);
    check("rstmid/ovf",    32'(result_ovf), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    check("rstmid/late_rdv_seen", 32'(total_rdv - rdv0), 32'd3);
    check("rstmid/late_result",   result, 32'd0);
    check("rstmid/late_idle",     32'({busy, done}), 32'd0);

    v2 = '{"after_rst", 2, 32'h200, 2, 2, 1'b0, 3, 32'd10, 1'b0, 1'b1, 0, 1'b0};
    run_job(v2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/start_job_engine.md
# start_job_engine

Consumer of the 1-bit start PIO output: receives the software start level, runs one read-and-accumulate job over a block of words in on-chip memory through an Avalon-MM master, and reports completion. `done` and `result` feed the done/result input PIOs. Software and hardware follow a 4-phase level handshake: start high, done high, start low, done low.

## Interface
Parameters:
- ADDR_W, 32: Avalon master address width.
- LEN_W, 11: width of `job_len`, the job length in words.
- MAX_OUT, 4: maximum outstanding pipelined reads, range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start level from the start PIO `out_port`; same clock domain.
- base_addr  in  ADDR_W  byte address of word 0; sampled at job start.
- job_len  in  LEN_W  number of 32-bit words; sampled at job start.
- avm_address  out  ADDR_W  read address, `base + 4*idx`.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; the request is accepted when `avm_read & ~avm_waitrequest`.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid; returns in request order.
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  job-complete level.
- result  out  32  sum of all words, modulo 2^32.
- result_ovf  out  1  high if any carry out of the 32-bit sum occurred in the job.

## Operation
States are IDLE, ISSUE, DRAIN and DONE.

- **IDLE**
  - If `start==1`:
    - latch `base_addr` and `job_len`;
    - clear `result`, `result_ovf`, `idx` and `rcv`;
    - go to ISSUE, or straight to DONE if `job_len==0`.
  - A `start` that is still high from a previous job cannot reach IDLE, because DONE only exits on `start==0`.
- **ISSUE**
  - `avm_read=1` while `idx<len` and `outstanding<MAX_OUT`.
  - The `avm_read` and `avm_address` values in a cycle are decided from the registered `idx` and `outstanding` only. No combinational path runs from `avm_readdatavalid` to `avm_read`.
  - `avm_read` and `avm_address` hold stable while `avm_waitrequest` is high.
  - Each acceptance increments `idx` and `outstanding`.
  - Go to DRAIN in the cycle after the request with `idx==len-1` is accepted.
- **DRAIN**
  - `avm_read=0`.
  - Stay until `rcv==len`, then go to DONE.
- **Data path (ISSUE and DRAIN)**
  - Each `avm_readdatavalid`: `result<=result+avm_readdata`, `rcv++`, `outstanding--`.
  - A carry out of bit 31 sets `result_ovf` (sticky for the job).
  - An acceptance and a readdatavalid in the same cycle leave `outstanding` unchanged.
- **DONE**
  - `done=1`; `result` and `result_ovf` are frozen.
  - Exit to IDLE when `start==0`, so `done` is high for at least 1 cycle.
  - `result` is held until the next job start.
- **start deasserted mid-job**: ignored. The job completes, `done` is high for exactly 1 cycle, and `result` is valid.
- **Spurious readdatavalid**: `avm_readdatavalid` in IDLE or DONE is ignored.
- **Widths**: `idx`, `rcv` and `len` are LEN_W+1 bits so the full `job_len` range works. The `4*idx` offset is computed in ADDR_W bits and wraps at the top of the address space.

## Timing
- **Reset values** (forced immediately by reset, any state): state=IDLE; `avm_read`, `busy`, `done`, `result_ovf` = 0; `result` = 0; `avm_address` = 0.
  - Reset mid-job abandons any reads in flight. Their late `avm_readdatavalid` are ignored, because the engine is in IDLE.
- **Start latency**: `start` sampled high in cycle 0 gives `avm_read=1` with `avm_address=base` in cycle 1.
- **Throughput**: one request per cycle with zero waitrequest, provided read latency is at most MAX_OUT; otherwise the engine stalls on `outstanding`.
- **Completion**: final `avm_readdatavalid` in cycle k gives `result` updated and `done=1` in cycle k+1, with `busy=0` from k+1.
- **Zero-length job**: `job_len==0` with `start` high at cycle 0 gives `done=1` at cycle 1 and no bus activity.
- **Release**: `start` sampled low in DONE at cycle m gives `done=0` at m+1. `start` high again at m+1 or later begins a new job.

## Test plan
- **Basic job**: memory words 1..8, `base=0x100`, `job_len=8`, latency 2, no waitrequest.
  - Addresses 0x100..0x11C in 8 consecutive cycles.
  - `result=36`, `result_ovf=0`.
  - `done` rises 1 cycle after the last valid; falls 1 cycle after `start` goes low.
- **Backpressure**: as Basic job, with random `avm_waitrequest` (50%) and random latency 1..8.
  - Address and `avm_read` stable during stall.
  - Outstanding never exceeds MAX_OUT.
  - `result=36`.
- **Overflow**: `job_len=2`, words 0xFFFFFFFF and 0x00000002.
  - `result=0x00000001`, `result_ovf=1`.
- **Edge lengths**:
  - `job_len=0`: `done` at cycle 1, no `avm_read`.
  - `job_len=1`: single read, `result` = that word.
  - `job_len=2047`: `rcv` reaches 2047 and the job completes.
- **Handshake corners**:
  - `start` held high after `done`: no second job; `done` stays 1.
  - `start` dropped mid-job: job completes; `done` is a 1-cycle pulse; `result` correct.
- **Reset mid-DRAIN**: reset with 3 reads outstanding.
  - All outputs at reset values immediately.
  - Late `avm_readdatavalid` ignored.
  - Next job (words 5,5) gives `result=10`.
